// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order retirement stage below the ROB. It pops ready head entries,
// writes results to the regfile/RAT, handshakes stores with the store queue and flushes on mispredicts.
`default_nettype none

module rob_commit_ctrl #(
  parameter int ROB_IDX_W    = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [63:0]          rob_head,
  input  logic                 rob_empty,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  output logic                 rob_commit,
  output logic                 rf_ld,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_data,
  output logic [ROB_IDX_W-1:0] rf_tag,
  output logic                 st_commit,
  input  logic                 st_done,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic                 flush_busy,
  output logic [31:0]          retire_cnt
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_STORE_WAIT = 2'd1,
    S_FLUSH      = 2'd2
  } state_t;

  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_flush_cnt;
  logic [3:0]  w_flush_cnt_nxt;
  logic [31:0] r_retire_cnt;

  logic [31:0] w_value;
  logic [4:0]  w_rd;
  logic        w_ready;
  logic        w_is_store;
  logic        w_mispredict;
  logic        w_reg_write;
  logic        w_head_ok;
  logic        w_unused;

  assign w_value      = rob_head[31:0];
  assign w_rd         = rob_head[36:32];
  assign w_ready      = rob_head[37];
  assign w_is_store   = rob_head[38];
  assign w_mispredict = rob_head[39];
  assign w_reg_write  = rob_head[40];
  assign w_head_ok    = ~rob_empty & w_ready;
  assign w_unused     = ^rob_head[63:41];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_flush_cnt  <= 4'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_retire_cnt <= r_retire_cnt + {31'd0, rob_commit};
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    rob_commit      = 1'b0;
    rf_ld           = 1'b0;
    rf_rd           = 5'd0;
    rf_data         = 32'd0;
    rf_tag          = '0;
    st_commit       = 1'b0;
    flush           = 1'b0;
    redirect_pc     = 32'd0;
    flush_busy      = 1'b0;

    case (r_state)
      S_RUN: begin
        // A store takes priority over a mispredict flag on the same entry.
        if (w_head_ok && w_is_store) begin
          st_commit   = 1'b1;
          w_state_nxt = S_STORE_WAIT;
        end else if (w_head_ok) begin
          rob_commit = 1'b1;
          rf_ld      = w_reg_write & (w_rd != 5'd0);
          rf_rd      = w_rd;
          rf_data    = w_value;
          rf_tag     = rob_head_idx;
          if (w_mispredict) begin
            flush           = 1'b1;
            redirect_pc     = w_value;
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = c_FLUSH_LOAD;
          end
        end
      end
      S_STORE_WAIT: begin
        if (st_done) begin
          rob_commit  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        flush_busy = 1'b1;
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    // Reset suppresses every strobe so nothing is popped or reissued in that cycle.
    if (rst) begin
      rob_commit  = 1'b0;
      rf_ld       = 1'b0;
      st_commit   = 1'b0;
      flush       = 1'b0;
      redirect_pc = 32'd0;
      flush_busy  = 1'b0;
    end
  end

  assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: directed and random stimulus for rob_commit_ctrl, checked each cycle
// against a behavioural retirement model plus literal expectations.
`default_nettype none

module tb_rob_commit_ctrl;

  localparam int ROB_IDX_W    = 5;
  localparam int FLUSH_CYCLES = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [63:0]          rob_head;
  logic                 rob_empty;
  logic [ROB_IDX_W-1:0] rob_head_idx;
  logic                 rob_commit;
  logic                 rf_ld;
  logic [4:0]           rf_rd;
  logic [31:0]          rf_data;
  logic [ROB_IDX_W-1:0] rf_tag;
  logic                 st_commit;
  logic                 st_done;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic                 flush_busy;
  logic [31:0]          retire_cnt;

  rob_commit_ctrl #(
    .ROB_IDX_W    (ROB_IDX_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rob_head     (rob_head),
    .rob_empty    (rob_empty),
    .rob_head_idx (rob_head_idx),
    .rob_commit   (rob_commit),
    .rf_ld        (rf_ld),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .rf_tag       (rf_tag),
    .st_commit    (st_commit),
    .st_done      (st_done),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .flush_busy   (flush_busy),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: retired count, a store awaiting completion, remaining flush cycles.
  logic [31:0] m_cnt        = 32'd0;
  bit          m_store_wait = 1'b0;
  int          m_flush_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [63:0] mk(input bit rdy, input bit st, input bit mis, input bit rw,
                                     input logic [4:0] rd, input logic [31:0] val);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[31:0]  = val;
    h[36:32] = rd;
    h[37]    = rdy;
    h[38]    = st;
    h[39]    = mis;
    h[40]    = rw;
    return h;
  endfunction

  task automatic drive(input logic [63:0] head, input logic empty, input logic [4:0] idx,
                       input logic done, input logic r);
    @(negedge clk);
    rob_head     = head;
    rob_empty    = empty;
    rob_head_idx = idx;
    st_done      = done;
    rst          = r;
    #1;
  endtask

  // Compare every output with the model for the currently driven inputs, then advance it.
  task automatic settle();
    bit          e_commit, e_ld, e_st, e_flush, e_busy, head_ok;
    logic [31:0] e_pc;
    e_commit = 0; e_ld = 0; e_st = 0; e_flush = 0; e_busy = 0; e_pc = 32'd0;
    head_ok  = !rob_empty && rob_head[37];
    if (!rst) begin
      if (m_flush_left > 0) e_busy = 1;
      else if (m_store_wait) e_commit = st_done;
      else if (head_ok && rob_head[38]) e_st = 1;
      else if (head_ok) begin
        e_commit = 1;
        e_ld     = rob_head[40] && (rob_head[36:32] != 5'd0);
        if (rob_head[39]) begin
          e_flush = 1;
          e_pc    = rob_head[31:0];
        end
      end
    end
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("rob_commit", {31'd0, rob_commit}, {31'd0, e_commit});
    chk("rf_ld", {31'd0, rf_ld}, {31'd0, e_ld});
    chk("st_commit", {31'd0, st_commit}, {31'd0, e_st});
    chk("flush", {31'd0, flush}, {31'd0, e_flush});
    chk("flush_busy", {31'd0, flush_busy}, {31'd0, e_busy});
    if (e_ld) begin
      chk("rf_rd", {27'd0, rf_rd}, {27'd0, rob_head[36:32]});
      chk("rf_data", rf_data, rob_head[31:0]);
    end
    if (e_commit && !m_store_wait) chk("rf_tag", {27'd0, rf_tag}, {27'd0, rob_head_idx});
    if (e_flush) chk("redirect_pc", redirect_pc, e_pc);
    @(posedge clk);
    if (rst) begin
      m_cnt        = 32'd0;
      m_store_wait = 1'b0;
      m_flush_left = 0;
    end else begin
      if (e_commit) m_cnt = m_cnt + 32'd1;
      if (m_flush_left > 0) m_flush_left--;
      else if (m_store_wait && st_done) m_store_wait = 1'b0;
      else if (e_st) m_store_wait = 1'b1;
      if (e_flush) m_flush_left = FLUSH_CYCLES;
    end
  endtask

  task automatic cyc(input logic [63:0] head, input logic empty, input logic [4:0] idx,
                     input logic done, input logic r);
    drive(head, empty, idx, done, r);
    settle();
  endtask

  logic [63:0] idle_h;
  logic [63:0] st_h;

  initial begin
    idle_h = 64'd0;
    cyc(idle_h, 1'b1, 5'd0, 1'b0, 1'b1);
    cyc(idle_h, 1'b1, 5'd0, 1'b0, 1'b1);

    drive(mk(1, 0, 0, 1, 5'd5, 32'hDEADBEEF), 1'b0, 5'd3, 1'b0, 1'b0);
    chk("lit_reset_cnt", retire_cnt, 32'd0);
    chk("lit_commit", {31'd0, rob_commit}, 32'd1);
    chk("lit_rf_ld", {31'd0, rf_ld}, 32'd1);
    chk("lit_rf_rd", {27'd0, rf_rd}, 32'd5);
    chk("lit_rf_data", rf_data, 32'hDEADBEEF);
    chk("lit_rf_tag", {27'd0, rf_tag}, 32'd3);
    settle();
    drive(mk(1, 0, 0, 1, 5'd0, 32'h1234), 1'b0, 5'd4, 1'b0, 1'b0);
    chk("lit_cnt_one", retire_cnt, 32'd1);
    chk("lit_rd0_commit", {31'd0, rob_commit}, 32'd1);
    chk("lit_rd0_no_ld", {31'd0, rf_ld}, 32'd0);
    settle();
    for (int i = 0; i < 5; i++) cyc(mk(0, 0, 0, 1, 5'd7, 32'h55), 1'b0, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(mk(1, 0, 0, 1, 5'd7, 32'h66), 1'b1, 5'd5, 1'b0, 1'b0);
    drive(idle_h, 1'b1, 5'd5, 1'b0, 1'b0);
    chk("lit_cnt_held", retire_cnt, 32'd2);
    settle();

    // Store with completion three cycles after st_commit.
    st_h = mk(1, 1, 1, 1, 5'd9, 32'h77);
    drive(st_h, 1'b0, 5'd5, 1'b0, 1'b0);
    chk("lit_st_commit", {31'd0, st_commit}, 32'd1);
    settle();
    cyc(st_h, 1'b0, 5'd5, 1'b0, 1'b0);
    cyc(st_h, 1'b0, 5'd5, 1'b0, 1'b0);
    drive(st_h, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("lit_st_retire", {31'd0, rob_commit}, 32'd1);
    chk("lit_st_no_ld", {31'd0, rf_ld}, 32'd0);
    settle();
    cyc(idle_h, 1'b1, 5'd6, 1'b0, 1'b0);

    // Mispredict: flush pulse then two busy cycles that ignore a ready head.
    drive(mk(1, 0, 1, 0, 5'd1, 32'h0000_1000), 1'b0, 5'd6, 1'b0, 1'b0);
    chk("lit_flush", {31'd0, flush}, 32'd1);
    chk("lit_redirect", redirect_pc, 32'h0000_1000);
    settle();
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 0, 0, 1, 5'd2, 32'hAB), 1'b0, 5'd7, 1'b0, 1'b0);
      chk("lit_busy", {31'd0, flush_busy}, 32'd1);
      chk("lit_busy_nocommit", {31'd0, rob_commit}, 32'd0);
      settle();
    end
    drive(mk(1, 0, 0, 1, 5'd2, 32'hAB), 1'b0, 5'd7, 1'b0, 1'b0);
    chk("lit_after_flush", {31'd0, rob_commit}, 32'd1);
    settle();

    // Counter wrap.
    drive(idle_h, 1'b1, 5'd0, 1'b0, 1'b0);
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    cyc(mk(1, 0, 0, 1, 5'd3, 32'h1), 1'b0, 5'd1, 1'b0, 1'b0);
    drive(idle_h, 1'b1, 5'd1, 1'b0, 1'b0);
    chk("lit_wrap", retire_cnt, 32'd0);
    settle();

    // Reset while waiting on a store; a late st_done must not retire anything.
    cyc(mk(5, 0, 0, 0, 5'd0, 32'd0) | mk(1, 1, 0, 0, 5'd0, 32'd0), 1'b0, 5'd2, 1'b0, 1'b0);
    cyc(st_h, 1'b0, 5'd2, 1'b0, 1'b0);
    cyc(st_h, 1'b0, 5'd2, 1'b0, 1'b1);
    drive(idle_h, 1'b1, 5'd0, 1'b1, 1'b0);
    chk("lit_rst_cnt", retire_cnt, 32'd0);
    chk("lit_rst_no_commit", {31'd0, rob_commit}, 32'd0);
    chk("lit_rst_no_st", {31'd0, st_commit}, 32'd0);
    settle();

    for (int i = 0; i < 1500; i++) begin
      cyc(mk($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             1'($urandom), 5'($urandom), $urandom),
          $urandom_range(0, 4) == 0, 5'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 60) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
